mul_div_unit: RTL

Parametrised iterative RV M-extension multiply/divide unit for the EXE stage.
Executes all eight M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) at width XLEN: shift-add multiply, restoring divide, one bit per cycle.
Uses a valid/ready request/response handshake with flush, replacing level-held req/ready.
Gives full RISC-V special-case semantics: div-by-zero, signed overflow, remainder sign.

---
 rtl/mul_div_pkg.sv | 53 +++++
 rtl/mul_div_if.sv | 30 +++
 rtl/mul_div_operand_prep.sv | 45 ++++
 rtl/mul_div_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative M-extension multiply/divide unit.
// Contents: funct3 op codes, the FSM state type, the operand flag bundle, and
// helper functions that classify an op by signedness and result selection.
package mul_div_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_MUL    = 3'd0;
    localparam logic [OP_W-1:0] OP_MULH   = 3'd1;
    localparam logic [OP_W-1:0] OP_MULHSU = 3'd2;
    localparam logic [OP_W-1:0] OP_MULHU  = 3'd3;
    localparam logic [OP_W-1:0] OP_DIV    = 3'd4;
    localparam logic [OP_W-1:0] OP_DIVU   = 3'd5;
    localparam logic [OP_W-1:0] OP_REM    = 3'd6;
    localparam logic [OP_W-1:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Sign flags of the original operands and the special cases found at accept.
    typedef struct packed {
        logic neg_a;
        logic neg_b;
        logic mul_zero;
        logic div_zero;
        logic div_ovf;
    } op_flags_t;

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [OP_W-1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [OP_W-1:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic want_high(input logic [OP_W-1:0] op);
        return !op[2] && (op != OP_MUL);
    endfunction

    function automatic logic is_rem(input logic [OP_W-1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/mul_div_if.sv
// Request/response handshake bundle of the multiply/divide unit.
// Signal names are from the unit's point of view:
//   req_valid_i/req_ready_o, op_i, rs1_i, rs2_i  - request channel
//   resp_valid_o/resp_ready_i, result_o          - response channel
// slave  : the unit; master : the issuing pipeline stage.
interface mul_div_if #(
    parameter int unsigned XLEN = 32
);
    import mul_div_pkg::*;

    logic                req_valid_i;
    logic                req_ready_o;
    logic [OP_W-1:0]     op_i;
    logic [XLEN-1:0]     rs1_i;
    logic [XLEN-1:0]     rs2_i;
    logic                resp_valid_o;
    logic                resp_ready_i;
    logic [XLEN-1:0]     result_o;

    modport slave (
        input  req_valid_i, op_i, rs1_i, rs2_i, resp_ready_i,
        output req_ready_o, resp_valid_o, result_o
    );

    modport master (
        output req_valid_i, op_i, rs1_i, rs2_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, result_o
    );

endinterface

// File: rtl/mul_div_operand_prep.sv
// Combinational operand preparation: converts signed operands to magnitudes,
// records the original signs and detects the special cases.
// Ports:
//   op_i     in  funct3 op
//   rs1_i    in  operand A / dividend
//   rs2_i    in  operand B / divisor
//   mag_a_c  out |rs1| (or rs1 when treated unsigned)
//   mag_b_c  out |rs2| (or rs2 when treated unsigned)
//   flags_c  out sign flags and special-case flags
module mul_div_operand_prep
    import mul_div_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [OP_W-1:0] op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] mag_a_c,
    output logic [XLEN-1:0] mag_b_c,
    output op_flags_t       flags_c
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic sign_a;
    logic sign_b;

    // Magnitude and sign extraction plus special-case detection.
    always_comb begin
        sign_a = is_signed_a(op_i) && rs1_i[XLEN-1];
        sign_b = is_signed_b(op_i) && rs2_i[XLEN-1];

        mag_a_c = sign_a ? -rs1_i : rs1_i;
        mag_b_c = sign_b ? -rs2_i : rs2_i;

        flags_c          = '0;
        flags_c.neg_a    = sign_a;
        flags_c.neg_b    = sign_b;
        flags_c.mul_zero = !is_div(op_i) && ((rs1_i == '0) || (rs2_i == '0));
        flags_c.div_zero = is_div(op_i) && (rs2_i == '0);
        flags_c.div_ovf  = is_div(op_i) && is_signed_b(op_i) &&
                           (rs1_i == MIN_NEG) && (rs2_i == '1);
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV M-extension multiply/divide unit (shift-add multiply,
// restoring divide, one bit per cycle) with valid/ready handshake and flush.
// Ports:
//   clk_i   in  clock, rising edge
//   rst_ni  in  asynchronous active-low reset
//   flush_i in  abort the in-flight op / block acceptance while idle
//   busy_o  out unit is not idle
//   bus     slave modport of mul_div_if (request and response channels)
// Optional build macro: MUL_DIV_EARLY_OUT_EN - ops whose result is fully
// determined at accept (mul operand zero, div by zero, signed overflow) go
// straight from IDLE to DONE and respond one cycle after accept.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    output logic         busy_o,
    mul_div_if.slave     bus
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned ACC_W = 2 * XLEN + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    op_flags_t         flags_q, flags_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              resp_valid_q, resp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;

    logic [XLEN-1:0]   prep_mag_a_c;
    logic [XLEN-1:0]   prep_mag_b_c;
    op_flags_t         prep_flags_c;

    logic [XLEN:0]     mul_sum_c;
    logic [ACC_W-1:0]  mul_step_c;
    logic [ACC_W-1:0]  div_shift_c;
    logic [XLEN:0]     div_diff_c;
    logic [ACC_W-1:0]  div_step_c;

    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   quot_c;
    logic [XLEN-1:0]   rem_c;
    logic [XLEN-1:0]   dividend_c;
    logic [XLEN-1:0]   fix_result_c;

    mul_div_operand_prep #(
        .XLEN (XLEN)
    ) u_prep (
        .op_i    (bus.op_i),
        .rs1_i   (bus.rs1_i),
        .rs2_i   (bus.rs2_i),
        .mag_a_c (prep_mag_a_c),
        .mag_b_c (prep_mag_b_c),
        .flags_c (prep_flags_c)
    );

    // One iteration of each algorithm. The multiplier sits in acc[XLEN-1:0]
    // and is consumed LSB first; the extra top bit holds the add carry.
    always_comb begin
        mul_sum_c   = acc_q[ACC_W-1:XLEN] + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        mul_step_c  = {mul_sum_c, acc_q[XLEN-1:0]} >> 1;

        // Restoring divide: {rem,quot} shifts left, the quotient bit enters at bit 0.
        div_shift_c = {acc_q[2*XLEN-1:0], 1'b0};
        div_diff_c  = div_shift_c[ACC_W-1:XLEN] - {1'b0, mag_b_q};
        div_step_c  = div_diff_c[XLEN] ? div_shift_c
                                       : {div_diff_c, div_shift_c[XLEN-1:1], 1'b1};
    end

    // Sign correction, special-case override and result selection.
    always_comb begin
        prod_c     = (flags_q.neg_a ^ flags_q.neg_b) ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
        quot_c     = (flags_q.neg_a ^ flags_q.neg_b) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_c      = flags_q.neg_a ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        dividend_c = flags_q.neg_a ? -mag_a_q : mag_a_q;
        fix_result_c = '0;

        if (flags_q.div_zero) begin
            quot_c = '1;
            rem_c  = dividend_c;
        end else if (flags_q.div_ovf) begin
            quot_c = MIN_NEG;
            rem_c  = '0;
        end

        if (is_div(op_q)) begin
            fix_result_c = is_rem(op_q) ? rem_c : quot_c;
        end else if (!flags_q.mul_zero) begin
            fix_result_c = want_high(op_q) ? prod_c[2*XLEN-1:XLEN] : prod_c[XLEN-1:0];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        op_d         = op_q;
        mag_a_d      = mag_a_q;
        mag_b_d      = mag_b_q;
        flags_d      = flags_q;
        result_d     = result_q;
        resp_valid_d = resp_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid_i && !flush_i) begin
                    op_d    = bus.op_i;
                    mag_a_d = prep_mag_a_c;
                    mag_b_d = prep_mag_b_c;
                    flags_d = prep_flags_c;
                    acc_d   = {{(XLEN+1){1'b0}}, prep_mag_a_c};
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef MUL_DIV_EARLY_OUT_EN
                    if (prep_flags_c.mul_zero || prep_flags_c.div_zero || prep_flags_c.div_ovf) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                acc_d = is_div(op_q) ? div_step_c : mul_step_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d     = fix_result_c;
                resp_valid_d = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                // DONE without a valid response only occurs on the early-out path.
                if (!resp_valid_q) begin
                    result_d     = fix_result_c;
                    resp_valid_d = 1'b1;
                end else if (bus.resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A pipeline kill overrides everything, including a completing response.
        if (flush_i && (state_q != IDLE)) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
        end

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            op_q         <= '0;
            mag_a_q      <= '0;
            mag_b_q      <= '0;
            flags_q      <= '0;
            result_q     <= '0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            op_q         <= op_d;
            mag_a_q      <= mag_a_d;
            mag_b_q      <= mag_b_d;
            flags_q      <= flags_d;
            result_q     <= result_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready_o  = req_ready_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.result_o     = result_q;
    assign busy_o           = busy_q;

endmodule
